ipsxb_ddrphy_pll_seq: RTL and testbench



---
 rtl/ipsxb_ddrphy_pll_seq.sv | 198 +++++++++++++++++++
 tb/tb_ipsxb_ddrphy_pll_seq.sv | 396 +++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ipsxb_ddrphy_pll_seq.sv
// ipsxb_ddrphy_pll_seq: bring-up and supervision sequencer for one to four DDR PHY PLLs.
// Holds the PLLs in reset, waits for a stable lock, opens the output-clock gates in index
// order and re-sequences on lock loss or lock timeout with a bounded retry count.
// Optional macro IPSXB_PLL_SEQ_LOCK_SYNC_EN inserts a two-flop synchroniser on pll_lock.
module ipsxb_ddrphy_pll_seq #(
    parameter int unsigned NUM_PLL      = 2,
    parameter int unsigned RST_CYCLES   = 16,
    parameter int unsigned LOCK_STABLE  = 64,
    parameter int unsigned LOCK_TIMEOUT = 4096,
    parameter int unsigned GATE_GAP     = 8,
    parameter int unsigned MAX_RETRY    = 3
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               restart,
    input  logic [NUM_PLL-1:0] pll_lock,
    output logic [NUM_PLL-1:0] pll_rst,
    output logic [NUM_PLL-1:0] clkout_gate,
    output logic               ready,
    output logic               fail,
    output logic [2:0]         state,
    output logic [3:0]         retry_cnt
);

    function automatic int unsigned max2(int unsigned a, int unsigned b);
        return (a > b) ? a : b;
    endfunction

    localparam int unsigned TmrMax = max2(max2(RST_CYCLES, LOCK_STABLE),
                                          max2(LOCK_TIMEOUT, GATE_GAP));
    localparam int unsigned TW = (TmrMax > 1) ? $clog2(TmrMax) : 1;

    localparam logic [TW-1:0]      RstLast     = TW'(RST_CYCLES - 1);
    localparam logic [TW-1:0]      TimeoutLast = TW'(LOCK_TIMEOUT - 1);
    localparam logic [TW-1:0]      StableLast  = TW'(LOCK_STABLE - 1);
    localparam logic [TW-1:0]      GapLast     = TW'(GATE_GAP - 1);
    localparam logic [TW-1:0]      TmrSat      = '1;
    localparam logic [1:0]         GateLast    = 2'(NUM_PLL - 1);
    localparam logic [3:0]         RetryMax    = 4'(MAX_RETRY);
    localparam logic [NUM_PLL-1:0] GateOne     = NUM_PLL'(1);

    typedef enum logic [2:0] {
        StReset    = 3'd0,
        StWaitLock = 3'd1,
        StStable   = 3'd2,
        StGate     = 3'd3,
        StReady    = 3'd4,
        StFail     = 3'd5
    } state_e;

    state_e             state_q, state_d;
    logic [TW-1:0]      timer_q, timer_d;
    logic [1:0]         gate_idx_q, gate_idx_d;
    logic [3:0]         retry_q, retry_d;
    logic [NUM_PLL-1:0] pll_rst_q, pll_rst_d;
    logic [NUM_PLL-1:0] gate_q, gate_d;
    logic               ready_q, ready_d;
    logic               fail_q, fail_d;
    logic               tmr_clr;
    logic               gate_step;
    logic               do_retry;
    logic               lock_all;

`ifdef IPSXB_PLL_SEQ_LOCK_SYNC_EN
    logic [NUM_PLL-1:0] lock_meta_q, lock_sync_q;

    // Two-flop synchroniser per lock bit; pll_lock is asynchronous to clk.
    always_ff @(posedge clk) begin
        if (rst) begin
            lock_meta_q <= '0;
            lock_sync_q <= '0;
        end else begin
            lock_meta_q <= pll_lock;
            lock_sync_q <= lock_meta_q;
        end
    end

    assign lock_all = &lock_sync_q;
`else
    assign lock_all = &pll_lock;
`endif

    // State register plus the shared timer, gate index and retry counter.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= StReset;
            timer_q    <= '0;
            gate_idx_q <= '0;
            retry_q    <= '0;
        end else begin
            state_q    <= state_d;
            timer_q    <= timer_d;
            gate_idx_q <= gate_idx_d;
            retry_q    <= retry_d;
        end
    end

    // Next-state logic; the retry decision is folded into the transition edge.
    always_comb begin
        state_d    = state_q;
        retry_d    = retry_q;
        gate_idx_d = gate_idx_q;
        tmr_clr    = 1'b0;
        gate_step  = 1'b0;
        do_retry   = 1'b0;
        timer_d    = timer_q;
        if (restart) begin
            state_d = StReset;
            retry_d = '0;
            tmr_clr = 1'b1;
        end else begin
            unique case (state_q)
                StReset: begin
                    if (timer_q == RstLast) state_d = StWaitLock;
                end
                StWaitLock: begin
                    if (lock_all) state_d = StStable;
                    else if (timer_q == TimeoutLast) do_retry = 1'b1;
                end
                StStable: begin
                    if (!lock_all) begin
                        do_retry = 1'b1;
                    end else if (timer_q == StableLast) begin
                        state_d    = (NUM_PLL == 1) ? StReady : StGate;
                        gate_idx_d = 2'd1;
                    end
                end
                StGate: begin
                    if (!lock_all) begin
                        do_retry = 1'b1;
                    end else if (timer_q == GapLast) begin
                        gate_step  = 1'b1;
                        gate_idx_d = gate_idx_q + 2'd1;
                        if (gate_idx_q == GateLast) state_d = StReady;
                    end
                end
                StReady: begin
                    if (!lock_all) do_retry = 1'b1;
                end
                StFail: begin
                    state_d = StFail;
                end
                default: begin
                    state_d = StReset;
                end
            endcase
            if (do_retry) begin
                if (retry_q == RetryMax) begin
                    state_d = StFail;
                end else begin
                    retry_d = retry_q + 4'd1;
                    state_d = StReset;
                end
            end
        end
        // Timer restarts on every transition and per gate release; saturates otherwise.
        if (tmr_clr || gate_step || (state_d != state_q)) timer_d = '0;
        else if (timer_q != TmrSat) timer_d = timer_q + TW'(1);
    end

    // Next values of the registered outputs, derived from the upcoming state.
    always_comb begin
        pll_rst_d = {NUM_PLL{(state_d == StReset) || (state_d == StFail)}};
        ready_d   = (state_d == StReady);
        fail_d    = (state_d == StFail);
        gate_d    = gate_q;
        if (state_d inside {StReset, StWaitLock, StStable, StFail}) begin
            gate_d = '0;
        end else if (state_q == StStable) begin
            gate_d = GateOne;
        end else if (gate_step) begin
            gate_d = gate_q | (GateOne << gate_idx_q);
        end
    end

    // Output registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            pll_rst_q <= '1;
            gate_q    <= '0;
            ready_q   <= 1'b0;
            fail_q    <= 1'b0;
        end else begin
            pll_rst_q <= pll_rst_d;
            gate_q    <= gate_d;
            ready_q   <= ready_d;
            fail_q    <= fail_d;
        end
    end

    assign pll_rst     = pll_rst_q;
    assign clkout_gate = gate_q;
    assign ready       = ready_q;
    assign fail        = fail_q;
    assign state       = state_q;
    assign retry_cnt   = retry_q;

endmodule

// File: tb/tb_ipsxb_ddrphy_pll_seq.sv
// Self-checking bench for ipsxb_ddrphy_pll_seq: constant vector table, hand-written corner
// sequences and a randomized run, all shadowed cycle by cycle by a phase/count model.
`timescale 1ns/1ps
module tb_ipsxb_ddrphy_pll_seq;

    localparam int NUM_PLL      = 2;
    localparam int RST_CYCLES   = 16;
    localparam int LOCK_STABLE  = 64;
    localparam int LOCK_TIMEOUT = 4096;
    localparam int GATE_GAP     = 8;
    localparam int MAX_RETRY    = 3;
`ifdef IPSXB_PLL_SEQ_LOCK_SYNC_EN
    localparam int LAT = 2;
`else
    localparam int LAT = 0;
`endif

    localparam int PH_RESET  = 0;
    localparam int PH_WAIT   = 1;
    localparam int PH_LOCKED = 2;
    localparam int PH_FAIL   = 3;
    localparam int CNT_CAP   = LOCK_STABLE + (NUM_PLL - 1) * GATE_GAP;

    logic               clk = 1'b0;
    logic               rst;
    logic               restart;
    logic [NUM_PLL-1:0] pll_lock;
    logic [NUM_PLL-1:0] pll_rst;
    logic [NUM_PLL-1:0] clkout_gate;
    logic               ready;
    logic               fail;
    logic [2:0]         state;
    logic [3:0]         retry_cnt;

    ipsxb_ddrphy_pll_seq #(
        .NUM_PLL     (NUM_PLL),
        .RST_CYCLES  (RST_CYCLES),
        .LOCK_STABLE (LOCK_STABLE),
        .LOCK_TIMEOUT(LOCK_TIMEOUT),
        .GATE_GAP    (GATE_GAP),
        .MAX_RETRY   (MAX_RETRY)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .restart    (restart),
        .pll_lock   (pll_lock),
        .pll_rst    (pll_rst),
        .clkout_gate(clkout_gate),
        .ready      (ready),
        .fail       (fail),
        .state      (state),
        .retry_cnt  (retry_cnt)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    // Reference model: a phase plus an elapsed-cycle count; gates derive arithmetically.
    int m_phase = PH_RESET;
    int m_cnt   = 0;
    int m_retry = 0;
`ifdef IPSXB_PLL_SEQ_LOCK_SYNC_EN
    bit m_h1 = 1'b0;
    bit m_h2 = 1'b0;
`endif

    typedef struct {
        int                 edges;
        logic [2:0]         st;
        logic [NUM_PLL-1:0] gate;
        logic               rdy;
        logic [NUM_PLL-1:0] prst;
    } vec_t;

    vec_t vecs [8];

    function automatic int m_open();
        int n;
        if (m_phase != PH_LOCKED || m_cnt < LOCK_STABLE) return 0;
        n = 1 + (m_cnt - LOCK_STABLE) / GATE_GAP;
        return (n > NUM_PLL) ? NUM_PLL : n;
    endfunction

    task automatic m_retry_now();
        if (m_retry == MAX_RETRY) begin
            m_phase = PH_FAIL;
        end else begin
            m_retry = m_retry + 1;
            m_phase = PH_RESET;
        end
        m_cnt = 0;
    endtask

    // Advance the model by one clock using the inputs the DUT is about to sample.
    task automatic model_step();
        bit le;
`ifdef IPSXB_PLL_SEQ_LOCK_SYNC_EN
        le = m_h2;
        if (rst) begin
            m_h1 = 1'b0;
            m_h2 = 1'b0;
        end else begin
            m_h2 = m_h1;
            m_h1 = &pll_lock;
        end
`else
        le = &pll_lock;
`endif
        if (rst || restart) begin
            m_phase = PH_RESET;
            m_cnt   = 0;
            m_retry = 0;
        end else begin
            case (m_phase)
                PH_RESET: begin
                    m_cnt = m_cnt + 1;
                    if (m_cnt == RST_CYCLES) begin
                        m_phase = PH_WAIT;
                        m_cnt   = 0;
                    end
                end
                PH_WAIT: begin
                    if (le) begin
                        m_phase = PH_LOCKED;
                        m_cnt   = 0;
                    end else begin
                        m_cnt = m_cnt + 1;
                        if (m_cnt == LOCK_TIMEOUT) m_retry_now();
                    end
                end
                PH_LOCKED: begin
                    if (!le) m_retry_now();
                    else if (m_cnt < CNT_CAP) m_cnt = m_cnt + 1;
                end
                default: ;
            endcase
        end
    endtask

    task automatic check_model();
        int                 n;
        int                 st;
        logic [NUM_PLL-1:0] eg;
        logic [NUM_PLL-1:0] er;
        logic               erdy;
        logic               efail;
        n     = m_open();
        eg    = NUM_PLL'((1 << n) - 1);
        er    = (m_phase == PH_RESET || m_phase == PH_FAIL) ? '1 : '0;
        erdy  = (n == NUM_PLL);
        efail = (m_phase == PH_FAIL);
        case (m_phase)
            PH_RESET:  st = 0;
            PH_WAIT:   st = 1;
            PH_LOCKED: st = (n == 0) ? 2 : ((n < NUM_PLL) ? 3 : 4);
            default:   st = 5;
        endcase
        n_tests = n_tests + 1;
        if (state !== 3'(st) || pll_rst !== er || clkout_gate !== eg || ready !== erdy ||
            fail !== efail || retry_cnt !== 4'(m_retry)) begin
            n_fail = n_fail + 1;
            $display("FAIL model @%0t: got state=%0d pll_rst=%b gate=%b ready=%b fail=%b retry=%0d, want state=%0d pll_rst=%b gate=%b ready=%b fail=%b retry=%0d",
                     $time, state, pll_rst, clkout_gate, ready, fail, retry_cnt,
                     st, er, eg, erdy, efail, m_retry);
        end
    endtask

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
        n_tests = n_tests + 1;
        if (got !== want) begin
            n_fail = n_fail + 1;
            $display("FAIL %s: got %0d, want %0d", name, got, want);
        end
    endtask

    task automatic tick();
        model_step();
        @(posedge clk);
        #1;
        check_model();
    endtask

    task automatic do_reset();
        rst     = 1'b1;
        restart = 1'b0;
        tick();
        tick();
        rst = 1'b0;
    endtask

    // Bounded wait for a state value; an expired budget shows up as a failed check.
    task automatic wait_state(input int want, input int budget, input string name);
        int cnt;
        cnt = 0;
        while (state !== 3'(want) && cnt < budget) begin
            tick();
            cnt = cnt + 1;
        end
        check(name, state, want);
    endtask

    task automatic drop_lock(input int bit_idx);
        pll_lock[bit_idx] = 1'b0;
        tick();
        pll_lock = '1;
        repeat (LAT) tick();
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int cnt;
        bit gate_seen;

        vecs[0] = '{edges: 15,  st: 3'd0, gate: 2'b00, rdy: 1'b0, prst: 2'b11};
        vecs[1] = '{edges: 16,  st: 3'd1, gate: 2'b00, rdy: 1'b0, prst: 2'b00};
        vecs[2] = '{edges: 17,  st: 3'd2, gate: 2'b00, rdy: 1'b0, prst: 2'b00};
        vecs[3] = '{edges: 80,  st: 3'd2, gate: 2'b00, rdy: 1'b0, prst: 2'b00};
        vecs[4] = '{edges: 81,  st: 3'd3, gate: 2'b01, rdy: 1'b0, prst: 2'b00};
        vecs[5] = '{edges: 88,  st: 3'd3, gate: 2'b01, rdy: 1'b0, prst: 2'b00};
        vecs[6] = '{edges: 89,  st: 3'd4, gate: 2'b11, rdy: 1'b1, prst: 2'b00};
        vecs[7] = '{edges: 200, st: 3'd4, gate: 2'b11, rdy: 1'b1, prst: 2'b00};

        rst      = 1'b1;
        restart  = 1'b0;
        pll_lock = '0;

        // Reset values.
        do_reset();
        check("rst_pll_rst", pll_rst, 2'b11);
        check("rst_gate", clkout_gate, 0);
        check("rst_ready", ready, 0);
        check("rst_fail", fail, 0);
        check("rst_state", state, 0);
        check("rst_retry", retry_cnt, 0);

        // Vector table: locks held high from reset, outputs after N edges.
        for (int i = 0; i < 8; i++) begin
            pll_lock = '1;
            do_reset();
            repeat (vecs[i].edges) tick();
            check("vec_state", state, vecs[i].st);
            check("vec_gate", clkout_gate, vecs[i].gate);
            check("vec_ready", ready, vecs[i].rdy);
            check("vec_pll_rst", pll_rst, vecs[i].prst);
        end

        // Bring-up: reset hold length, lock-to-gate latency, gate spacing.
        pll_lock = '0;
        do_reset();
        cnt = 0;
        while (pll_rst !== '0 && cnt < 100) begin
            tick();
            cnt = cnt + 1;
        end
        check("rst_hold", cnt, RST_CYCLES);
        repeat (10) tick();
        pll_lock = '1;
        cnt = 0;
        do begin
            tick();
            cnt = cnt + 1;
        end while (clkout_gate[0] !== 1'b1 && cnt < 500);
        check("gate0_lat", cnt, LOCK_STABLE + 1 + LAT);
        check("gate1_not_yet", clkout_gate[NUM_PLL-1], 0);
        cnt = 0;
        while (clkout_gate[NUM_PLL-1] !== 1'b1 && cnt < 100) begin
            tick();
            cnt = cnt + 1;
        end
        check("gate1_gap", cnt, GATE_GAP);
        check("bringup_ready", ready, 1);
        check("bringup_state", state, 4);

        // One-cycle lock drop in READY.
        drop_lock(0);
        check("drop_gate", clkout_gate, 0);
        check("drop_ready", ready, 0);
        check("drop_retry", retry_cnt, 1);
        check("drop_state", state, 0);
        check("drop_pll_rst", pll_rst, 2'b11);

        // Lock drop seen in the last STABLE cycle (timer 63).
        wait_state(2, 200, "reach_stable");
        gate_seen = 1'b0;
        repeat (LOCK_STABLE - 1 - LAT) begin
            tick();
            gate_seen = gate_seen | (|clkout_gate);
        end
        pll_lock[1] = 1'b0;
        tick();
        gate_seen = gate_seen | (|clkout_gate);
        pll_lock = '1;
        repeat (LAT) begin
            tick();
            gate_seen = gate_seen | (|clkout_gate);
        end
        check("stable63_gate", gate_seen, 0);
        check("stable63_retry", retry_cnt, 2);
        check("stable63_state", state, 0);

        // Lock timeouts exhaust the retries.
        pll_lock = '1;
        pll_lock[NUM_PLL-1] = 1'b0;
        do_reset();
        for (int r = 1; r <= MAX_RETRY + 1; r++) begin
            wait_state(1, 100, "to_wait");
            cnt = 0;
            while (state === 3'd1 && cnt < LOCK_TIMEOUT + 100) begin
                tick();
                cnt = cnt + 1;
            end
            check("wait_len", cnt, LOCK_TIMEOUT);
            if (r <= MAX_RETRY) begin
                check("retry_step", retry_cnt, r);
                check("retry_state", state, 0);
            end
        end
        check("fail_flag", fail, 1);
        check("fail_state", state, 5);
        check("fail_pll_rst", pll_rst, 2'b11);
        check("fail_retry", retry_cnt, MAX_RETRY);
        check("fail_gate", clkout_gate, 0);

        // restart in FAIL coinciding with a lock drop.
        pll_lock = '1;
        repeat (3) tick();
        pll_lock[0] = 1'b0;
        restart = 1'b1;
        tick();
        restart = 1'b0;
        pll_lock = '1;
        check("restart_state", state, 0);
        check("restart_fail", fail, 0);
        check("restart_retry", retry_cnt, 0);
        check("restart_pll_rst", pll_rst, 2'b11);

        // restart wins over a simultaneous lock loss in READY.
        wait_state(4, 300, "ready_f1");
        drop_lock(1);
        check("f_retry1", retry_cnt, 1);
        wait_state(4, 300, "ready_f2");
        pll_lock[0] = 1'b0;
        restart = 1'b1;
        tick();
        restart = 1'b0;
        pll_lock = '1;
        check("prio_state", state, 0);
        check("prio_retry", retry_cnt, 0);
        check("prio_gate", clkout_gate, 0);
        repeat (LAT + 1) tick();
        check("prio_retry_late", retry_cnt, 0);

        // rst while gates are partly open.
        wait_state(4, 300, "ready_g");
        drop_lock(0);
        wait_state(3, 300, "reach_gate");
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("gate_rst_state", state, 0);
        check("gate_rst_retry", retry_cnt, 0);
        check("gate_rst_gate", clkout_gate, 0);
        check("gate_rst_ready", ready, 0);
        check("gate_rst_fail", fail, 0);
        check("gate_rst_pll_rst", pll_rst, 2'b11);

        // Randomized run against the model.
        pll_lock = '1;
        do_reset();
        for (int i = 0; i < 20000; i++) begin
            restart = ($urandom_range(999) == 0);
            rst     = ($urandom_range(2999) == 0);
            for (int b = 0; b < NUM_PLL; b++) begin
                if (pll_lock[b]) begin
                    if ($urandom_range(399) == 0) pll_lock[b] = 1'b0;
                end else if ($urandom_range(3) == 0) begin
                    pll_lock[b] = 1'b1;
                end
            end
            tick();
        end
        rst     = 1'b0;
        restart = 1'b0;

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
